// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
package ram_arb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 7;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-input combinational grant: picks among eligible valid requesters, breaking ties
// against the last granted requester.
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] elig,
    input  req_id_t    last_grant,
    output logic [1:0] gnt_c,
    output req_id_t    gnt_id_c
);

    logic [1:0] cand;

    always_comb begin
        cand     = valid & elig;
        gnt_c    = 2'b00;
        gnt_id_c = REQ0;
        unique case (cand)
            2'b01: gnt_c = 2'b01;
            2'b10: begin
                gnt_c    = 2'b10;
                gnt_id_c = REQ1;
            end
            2'b11: begin
                if (last_grant == REQ1) begin
                    gnt_c = 2'b01;
                end else begin
                    gnt_c    = 2'b10;
                    gnt_id_c = REQ1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer in front of a single-port synchronous RAM with two valid/ready clients.
// Build option: RAM_ARB_FIXED_PRIO_EN gives requester 0 fixed priority on ties (no last_grant state).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_lock,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_lock,

    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int unsigned    CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam bit             LOCK_EN = (MAX_BURST > 1);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [1:0]       elig;
    logic [1:0]       gnt;
    req_id_t          gnt_id;
    req_id_t          arb_last;
    logic             gnt_lock;

    // Only the lock owner may be granted while a burst is open.
    always_comb begin
        elig = 2'b11;
        case (state)
            LOCK0:   elig = 2'b01;
            LOCK1:   elig = 2'b10;
            default: elig = 2'b11;
        endcase
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Pretending requester 1 went last makes requester 0 win every tie.
    assign arb_last = REQ1;
`else
    req_id_t last_grant, last_grant_nxt;

    always_comb begin
        last_grant_nxt = last_grant;
        if (|gnt) begin
            last_grant_nxt = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ1;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    assign arb_last = last_grant;
`endif

    rr_grant2 u_grant (
        .valid      ({req1_valid, req0_valid}),
        .elig       (elig),
        .last_grant (arb_last),
        .gnt_c      (gnt),
        .gnt_id_c   (gnt_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Burst sequencing: enter on a locked beat, leave on unlock, cap or owner going idle.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        gnt_lock      = (gnt_id == REQ1) ? req1_lock : req0_lock;
        case (state)
            ARB: begin
                if ((|gnt) && gnt_lock && LOCK_EN) begin
                    state_nxt     = (gnt_id == REQ1) ? LOCK1 : LOCK0;
                    burst_cnt_nxt = CNT_W'(1);
                end
            end
            LOCK0, LOCK1: begin
                if (!(|gnt)) begin
                    state_nxt     = ARB;
                    burst_cnt_nxt = '0;
                end else if (!gnt_lock || (burst_cnt + CNT_W'(1)) == CNT_MAX) begin
                    state_nxt     = ARB;
                    burst_cnt_nxt = '0;
                end else begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = ARB;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // RAM pins follow the winner in the grant cycle; idle pins are held at zero.
    always_comb begin
        mem_we      = 1'b0;
        mem_address = '0;
        mem_d       = '0;
        if (gnt[0]) begin
            mem_we      = req0_we;
            mem_address = req0_addr;
            mem_d       = req0_wdata;
        end else if (gnt[1]) begin
            mem_we      = req1_we;
            mem_address = req1_addr;
            mem_d       = req1_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rsp0_valid <= gnt[0] & ~req0_we;
            rsp1_valid <= gnt[1] & ~req1_we;
        end
    end

    // RAM output is already registered, so read data passes straight through in the response cycle.
    assign rsp_rdata = (rsp0_valid | rsp1_valid) ? mem_q : '0;

    a_one_grant: assert property (@(posedge clk) disable iff (reset)
        $onehot0({req1_ready, req0_ready}));
    a_rdy0_valid: assert property (@(posedge clk) disable iff (reset) req0_ready |-> req0_valid);
    a_rdy1_valid: assert property (@(posedge clk) disable iff (reset) req1_ready |-> req1_valid);
    a_cnt_bound: assert property (@(posedge clk) disable iff (reset) burst_cnt <= CNT_MAX);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, burst/reset sequences and a
// randomized run against a transaction-level model. Honours RAM_ARB_FIXED_PRIO_EN.
module tb_ram_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 7;
    localparam int unsigned MB = 8;

    logic          clk;
    logic          reset;
    logic          preload;
    logic          req0_valid, req0_ready, req0_we, req0_lock;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we, req1_lock;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_d, mem_q;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_address(mem_address), .mem_d(mem_d), .mem_q(mem_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port 128x32 synchronous RAM.
    logic [DW-1:0] ram [128];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        end else begin
            if (mem_we) ram[mem_address] <= mem_d;
            mem_q <= ram[mem_address];
        end
    end

    typedef struct {
        logic          v0, we0, lk0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1, lk1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic [1:0]    e_rdy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_d;
        logic [1:0]    e_rsp;
        logic [DW-1:0] e_rdata;
    } vec_t;

    int vectors;
    int miscompares;

    // Reference model state: who holds a lock, beats taken, last winner, pending read.
    int            lk_owner, beats, last_g, pend_id;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] ref_mem [128];

    logic [1:0]    obs_rdy, obs_rsp;
    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_d, obs_rdata;

    // ctl bits: {valid, we, lock}
    function automatic stim_t mk(input logic [2:0] c0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic [2:0] c1,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        stim_t s;
        {s.v0, s.we0, s.lk0} = c0;
        {s.v1, s.we1, s.lk1} = c1;
        s.a0 = a0; s.d0 = d0; s.a1 = a1; s.d1 = d1;
        return s;
    endfunction

    function automatic stim_t idle_s();
        return mk(3'b000, 7'd0, 32'd0, 3'b000, 7'd0, 32'd0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        req0_valid = s.v0; req0_we = s.we0; req0_lock = s.lk0; req0_addr = s.a0; req0_wdata = s.d0;
        req1_valid = s.v1; req1_we = s.we1; req1_lock = s.lk1; req1_addr = s.a1; req1_wdata = s.d1;
    endtask

    task automatic model_reset();
        lk_owner = -1; beats = 0; last_g = 1; pend_id = -1; pend_data = '0;
    endtask

    // One clock cycle: drive, predict, sample at the falling edge, then advance the model.
    task automatic cycle(input stim_t s);
        int            win;
        logic [1:0]    v, lk, we;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [1:0]    e_rdy, e_rsp;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_d;
        drive(s);
        v = {s.v1, s.v0}; lk = {s.lk1, s.lk0}; we = {s.we1, s.we0};
        a[0] = s.a0; a[1] = s.a1; d[0] = s.d0; d[1] = s.d1;
        win = -1;
        if (lk_owner >= 0) begin
            if (v[lk_owner]) win = lk_owner;
        end else if (v == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = (last_g == 0) ? 1 : 0;
`endif
        end else if (v[0]) begin
            win = 0;
        end else if (v[1]) begin
            win = 1;
        end
        e_rdy = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
        e_we = 1'b0; e_addr = '0; e_d = '0;
        if (win >= 0) begin
            e_we = we[win]; e_addr = a[win]; e_d = d[win];
        end
        e_rsp = (pend_id == 0) ? 2'b01 : (pend_id == 1) ? 2'b10 : 2'b00;

        @(negedge clk);
        obs_rdy = {req1_ready, req0_ready}; obs_rsp = {rsp1_valid, rsp0_valid};
        obs_we = mem_we; obs_addr = mem_address; obs_d = mem_d; obs_rdata = rsp_rdata;
        check("m_ready", 64'(obs_rdy), 64'(e_rdy));
        check("m_mem", 64'({obs_we, obs_addr, obs_d}), 64'({e_we, e_addr, e_d}));
        check("m_rsp", 64'(obs_rsp), 64'(e_rsp));
        if (pend_id >= 0) check("m_rdata", 64'(obs_rdata), 64'(pend_data));

        @(posedge clk);
        pend_id = -1;
        if (win >= 0) begin
            if (we[win]) begin
                ref_mem[a[win]] = d[win];
            end else begin
                pend_id = win;
                pend_data = ref_mem[a[win]];
            end
            last_g = win;
            if (lk_owner < 0) begin
                if (lk[win] && MB > 1) begin
                    lk_owner = win;
                    beats = 1;
                end
            end else begin
                beats++;
                if (!lk[win] || beats == MB) begin
                    lk_owner = -1;
                    beats = 0;
                end
            end
        end else if (lk_owner >= 0) begin
            lk_owner = -1;
            beats = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(idle_s());
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        check("rst_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_mem", 64'({mem_we, mem_address, mem_d}), 64'd0);
        reset = 1'b0;
        model_reset();
    endtask

    vec_t tbl [$];
    stim_t rs;
    int first_r1, exp_first;

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        preload = 1'b1;
        do_reset();
        preload = 1'b0;

        // Directed table; tie-break rows assume requester 0 won the reset tie first.
        tbl.push_back('{mk(3'b100, 7'd5, 32'd0, 3'b000, 7'd0, 32'd0), 2'b01, 1'b0, 7'd5, 32'd0, 2'b00, 32'd0});
        tbl.push_back('{idle_s(), 2'b00, 1'b0, 7'd0, 32'd0, 2'b01, 32'hA500_0005});
`ifdef RAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            tbl.push_back('{mk(3'b100, 7'd10, 32'd0, 3'b100, 7'd20, 32'd0), 2'b01, 1'b0, 7'd10, 32'd0,
                            (i == 0) ? 2'b00 : 2'b01, 32'hA500_000A});
        tbl.push_back('{idle_s(), 2'b00, 1'b0, 7'd0, 32'd0, 2'b01, 32'hA500_000A});
`else
        for (int i = 0; i < 4; i++)
            tbl.push_back('{mk(3'b100, 7'd10, 32'd0, 3'b100, 7'd20, 32'd0),
                            (i % 2 == 0) ? 2'b10 : 2'b01, 1'b0, (i % 2 == 0) ? 7'd20 : 7'd10, 32'd0,
                            (i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01,
                            (i % 2 == 1) ? 32'hA500_0014 : 32'hA500_000A});
        tbl.push_back('{idle_s(), 2'b00, 1'b0, 7'd0, 32'd0, 2'b01, 32'hA500_000A});
`endif
        tbl.push_back('{mk(3'b000, 7'd0, 32'd0, 3'b110, 7'd127, 32'hDEAD_BEEF), 2'b10, 1'b1, 7'd127, 32'hDEAD_BEEF, 2'b00, 32'd0});
        tbl.push_back('{mk(3'b000, 7'd0, 32'd0, 3'b100, 7'd127, 32'd0), 2'b10, 1'b0, 7'd127, 32'd0, 2'b00, 32'd0});
        tbl.push_back('{idle_s(), 2'b00, 1'b0, 7'd0, 32'd0, 2'b10, 32'hDEAD_BEEF});

        foreach (tbl[i]) begin
            cycle(tbl[i].s);
            check($sformatf("tbl%0d_ready", i), 64'(obs_rdy), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_mem", i), 64'({obs_we, obs_addr, obs_d}),
                  64'({tbl[i].e_we, tbl[i].e_addr, tbl[i].e_d}));
            check($sformatf("tbl%0d_rsp", i), 64'(obs_rsp), 64'(tbl[i].e_rsp));
            if (tbl[i].e_rsp != 2'b00)
                check($sformatf("tbl%0d_rdata", i), 64'(obs_rdata), 64'(tbl[i].e_rdata));
        end

        // Requester 0 holds lock with requester 1 pending throughout.
        do_reset();
        first_r1 = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(mk(3'b101, 7'(i), 32'd0, 3'b100, 7'd40, 32'd0));
            if (obs_rdy == 2'b10 && first_r1 < 0) first_r1 = i;
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_first = -1;
`else
        exp_first = int'(MB);
`endif
        check("burst_len", 64'(first_r1), 64'(exp_first));

        // Lock owner drops valid: one idle cycle, then the other requester.
        do_reset();
        cycle(mk(3'b101, 7'd1, 32'd0, 3'b100, 7'd2, 32'd0));
        check("drop_first", 64'(obs_rdy), 64'(2'b01));
        cycle(mk(3'b000, 7'd1, 32'd0, 3'b100, 7'd2, 32'd0));
        check("drop_idle", 64'(obs_rdy), 64'(2'b00));
        cycle(mk(3'b000, 7'd1, 32'd0, 3'b100, 7'd2, 32'd0));
        check("drop_next", 64'(obs_rdy), 64'(2'b10));
        cycle(idle_s());

        // Reset lands in the cycle a read response would appear.
        cycle(mk(3'b101, 7'd3, 32'd0, 3'b000, 7'd0, 32'd0));
        reset = 1'b1;
        drive(idle_s());
        #2;
        check("rst_drop_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        @(posedge clk);
        #1;
        check("rst_drop_rsp2", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        reset = 1'b0;
        model_reset();
        cycle(mk(3'b100, 7'd8, 32'd0, 3'b100, 7'd9, 32'd0));
        check("post_rst_tie", 64'(obs_rdy), 64'(2'b01));
        cycle(idle_s());

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rs.v0 = ($urandom_range(0, 3) != 0);
            rs.we0 = ($urandom_range(0, 2) == 0);
            rs.lk0 = ($urandom_range(0, 2) == 0);
            rs.a0 = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            rs.d0 = $urandom;
            rs.v1 = ($urandom_range(0, 3) != 0);
            rs.we1 = ($urandom_range(0, 2) == 0);
            rs.lk1 = ($urandom_range(0, 2) == 0);
            rs.a1 = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            rs.d1 = $urandom;
            cycle(rs);
        end
        cycle(idle_s());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
